param_up_down_counter: RTL and testbench

Parametrised up/down counter with a built-in programmable clock-enable divider, generalising the fixed 4-bit up/down counter with divider. It adds configurable width, a runtime modulus, a synchronous parallel load, wrap or saturate mode, and terminal-count flagging. All logic runs on the single system clock; the divider produces a one-cycle step enable and never generates a derived clock. It sits under timers and LED/display sequencers that need slow, direction-selectable counting.

---
 rtl/param_up_down_counter.sv | 81 ++++++++
 tb/tb_param_up_down_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Up/down counter with a runtime modulus, stepped by a programmable clock-enable divider.
// Synchronous load, wrap or saturate at the bounds, and one-cycle tick/tc pulses.
module param_up_down_counter #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sel,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic [WIDTH-1:0]     mod_max,
  input  logic                 sat_mode,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 step_due;
  logic [WIDTH-1:0]     step_count;
  logic                 step_tc;
  logic [WIDTH-1:0]     load_count;

  assign step_due   = (div_cnt == div_ratio);
  assign load_count = (load_val > mod_max) ? mod_max : load_val;

  // The next count if a step is applied this edge. A count left above a shrunk
  // modulus is pulled back to mod_max on a down step without flagging tc.
  always_comb begin
    step_count = count;
    step_tc    = 1'b0;
    if (!sel) begin
      if (count < mod_max) begin
        step_count = count + 1'b1;
      end else begin
        step_count = sat_mode ? mod_max : '0;
        step_tc    = 1'b1;
      end
    end else begin
      if (count > mod_max) begin
        step_count = mod_max;
      end else if (count != '0) begin
        step_count = count - 1'b1;
      end else begin
        step_count = sat_mode ? '0 : mod_max;
        step_tc    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (load) begin
      count   <= load_count;
      div_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (!enable) begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (step_due) begin
      count   <= step_count;
      div_cnt <= '0;
      tick    <= 1'b1;
      tc      <= step_tc;
    end else begin
      // A ratio lowered below div_cnt lets div_cnt run to its natural wrap.
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: a reference model pushes expected
// count/tick/tc per edge to a queue, popped and compared after the edge.
module tb_param_up_down_counter;
  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          sel;
  logic [DW-1:0] div_ratio;
  logic [W-1:0]  mod_max;
  logic          sat_mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          tick;
  logic          tc;

  typedef struct {
    logic [W-1:0] c;
    logic         t;
    logic         f;
  } exp_t;

  exp_t q[$];
  logic [W-1:0]  m_count;
  logic [DW-1:0] m_div;
  int n_tests = 0;
  int n_fail  = 0;
  int tc_seen;

  param_up_down_counter #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel), .div_ratio(div_ratio),
    .mod_max(mod_max), .sat_mode(sat_mode), .load(load), .load_val(load_val),
    .count(count), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one edge, from the currently driven inputs.
  task automatic model_edge();
    exp_t e;
    e.t = 1'b0;
    e.f = 1'b0;
    if (load) begin
      m_count = (load_val <= mod_max) ? load_val : mod_max;
      m_div   = '0;
    end else if (enable) begin
      if (m_div != div_ratio) begin
        m_div = m_div + 1'b1;
      end else begin
        m_div = '0;
        e.t   = 1'b1;
        if (sel == 1'b0) begin
          if (m_count >= mod_max) begin
            e.f     = 1'b1;
            m_count = sat_mode ? mod_max : W'(0);
          end else begin
            m_count = m_count + 1'b1;
          end
        end else begin
          if (m_count == 0) begin
            e.f     = 1'b1;
            m_count = sat_mode ? W'(0) : mod_max;
          end else if (m_count <= mod_max) begin
            m_count = m_count - 1'b1;
          end else begin
            m_count = mod_max;
          end
        end
      end
    end
    e.c = m_count;
    q.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".count"}, 32'(count), 32'(e.c));
    check({tag, ".tick"},  32'(tick),  32'(e.t));
    check({tag, ".tc"},    32'(tc),    32'(e.f));
    if (tc) tc_seen++;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    cyc("load");
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; sel = 1'b0; div_ratio = '0; mod_max = 4'd15;
    sat_mode = 1'b0; load = 1'b0; load_val = '0;
    m_count = '0; m_div = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.count", 32'(count), 0);
    check("reset.tick",  32'(tick),  0);
    check("reset.tc",    32'(tc),    0);
    #3 rst = 1'b1;

    // Reset mid-run, asynchronous assertion between edges.
    enable = 1'b1;
    repeat (5) cyc("run5");
    check("run5.final", 32'(count), 5);
    #3 rst = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 0);
    check("async_rst.tick",  32'(tick),  0);
    check("async_rst.tc",    32'(tc),    0);
    m_count = '0; m_div = '0;
    #1 rst = 1'b1;
    cyc("post_rst");
    check("post_rst.first", 32'(count), 1);

    // Wrap up at mod_max=9, period 10.
    mod_max = 4'd9;
    do_load(4'd0);
    tc_seen = 0;
    repeat (9) cyc("wrap");
    check("wrap.at9", 32'(count), 9);
    cyc("wrap0");
    check("wrap.to0", 32'(count), 0);
    check("wrap.tc0", 32'(tc), 1);
    repeat (10) cyc("wrap2");
    check("wrap.tc_count", 32'(tc_seen), 2);

    // Divider R=2 with a freeze.
    mod_max = 4'd15; div_ratio = 8'd2;
    do_load(4'd0);
    repeat (9) cyc("div");
    check("div.after9", 32'(count), 3);
    enable = 1'b0;
    repeat (4) cyc("freeze");
    check("freeze.count", 32'(count), 3);
    enable = 1'b1;
    repeat (2) cyc("resume");
    check("resume.notyet", 32'(count), 3);
    cyc("resume3");
    check("resume.step", 32'(count), 4);
    check("resume.tick", 32'(tick), 1);

    // Saturating down count from 2.
    div_ratio = 8'd0; sat_mode = 1'b1; sel = 1'b1;
    do_load(4'd2);
    check("satdn.load", 32'(count), 2);
    cyc("satdn1"); check("satdn.c1", 32'(count), 1); check("satdn.tc1", 32'(tc), 0);
    cyc("satdn0"); check("satdn.c0", 32'(count), 0); check("satdn.tc0", 32'(tc), 0);
    repeat (2) begin
      cyc("satdnh"); check("satdn.hold", 32'(count), 0); check("satdn.tch", 32'(tc), 1);
    end

    // Load clamp, and load beating a due step.
    sel = 1'b0; sat_mode = 1'b0; mod_max = 4'd9; div_ratio = 8'd2;
    do_load(4'd12);
    check("clamp", 32'(count), 9);
    repeat (2) cyc("pre_due");
    do_load(4'd3);
    check("ldprio.count", 32'(count), 3);
    check("ldprio.tick",  32'(tick),  0);
    repeat (2) cyc("ldprio_wait");
    check("ldprio.wait", 32'(count), 3);
    cyc("ldprio_step");
    check("ldprio.next", 32'(count), 4);

    // Modulus shrink and direction change.
    div_ratio = 8'd0; mod_max = 4'd15; enable = 1'b0;
    do_load(4'd12);
    mod_max = 4'd7; enable = 1'b1;
    cyc("shrink_up"); check("shrink.up", 32'(count), 0); check("shrink.uptc", 32'(tc), 1);
    enable = 1'b0; mod_max = 4'd15;
    do_load(4'd12);
    mod_max = 4'd7; sel = 1'b1; enable = 1'b1;
    cyc("shrink_dn"); check("shrink.dn", 32'(count), 7); check("shrink.dntc", 32'(tc), 0);
    cyc("shrink_dn2"); check("shrink.dn2", 32'(count), 6);

    // mod_max==0: pinned at 0, tc on each step.
    mod_max = 4'd0; sel = 1'b0;
    do_load(4'd5);
    repeat (3) begin
      cyc("mod0"); check("mod0.count", 32'(count), 0); check("mod0.tc", 32'(tc), 1);
    end

    // Lower the ratio below div_cnt: div_cnt has to wrap before the next step.
    mod_max = 4'd15; div_ratio = 8'd5;
    do_load(4'd0);
    repeat (4) cyc("lower_pre");
    div_ratio = 8'd1;
    repeat (20) cyc("lower_run");

    // Randomised stretch checked against the model.
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      load      = ($urandom_range(0, 19) == 0);
      load_val  = W'($urandom);
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(0, 15) == 0) mod_max = W'($urandom);
      if ($urandom_range(0, 31) == 0) div_ratio = DW'($urandom_range(0, 3));
      cyc("rand");
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
